gemm_issue_unit: RTL and testbench
==================================

GEMM_ISSUE_UNIT -- requirements
Module: gemm_issue_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, WAIT-state cycle limit before abort (only with GEMM_TIMEOUT_EN).
REQ-002 Parameter CNT_W, default 16, width of completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 is_gemm_ppl  input  1  pipelined GEMM-instruction flag from decode stage; held stable by pipeline while stalled.
REQ-006 flush  input  1  pipeline flush; qualifies acceptance only.
REQ-007 op_a  input  32  rs1 operand (source matrix base address).
REQ-008 op_b  input  32  rs2 operand (destination address / config word).
REQ-009 cmd_valid  output  1  command valid to accelerator.
REQ-010 cmd_ready  input  1  accelerator accepts command.
REQ-011 cmd_a, cmd_b  output  32 each  registered command payload.
REQ-012 gemm_done  input  1  single-cycle completion pulse from accelerator.
REQ-013 stall_req  output  1  freeze upstream pipeline.
REQ-014 busy  output  1  high when state is not IDLE.
REQ-015 done_cnt  output  CNT_W  completed operations, wraps modulo 2^CNT_W.
REQ-016 gemm_err  output  1  sticky timeout flag.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE; ERR-free encoding shared via package.
REQ-018 IDLE: is_gemm_ppl=1 and flush=0 -> capture op_a/op_b into cmd_a/cmd_b, clear gemm_err, go ISSUE; flush=1 -> stay IDLE, no capture.
REQ-019 ISSUE: cmd_valid=1, payload stable; cmd_ready=1 -> WAIT; otherwise remain; gemm_done ignored.
REQ-020 WAIT: gemm_done=1 -> DONE, done_cnt increments same edge.
REQ-021 DONE: one cycle, stall_req=0 so the GEMM instruction retires; is_gemm_ppl ignored; -> IDLE.
REQ-022 stall_req = (IDLE & is_gemm_ppl & ~flush) | ISSUE | WAIT, combinational.
REQ-023 cmd_valid registered-state decode only; no combinational path from cmd_ready to cmd_valid.
REQ-024 Latency: accept at cycle 0, cmd_valid at cycle 1; cmd_ready at 1 -> WAIT at 2; gemm_done at N -> DONE at N+1 (stall_req low), IDLE at N+2.
REQ-025 Back-to-back GEMM instructions: next accepted no earlier than IDLE cycle after DONE; never double-issue one instruction.
REQ-026 flush during ISSUE/WAIT/DONE has no effect.

Reset
REQ-027 rst low asynchronously forces IDLE; cmd_valid=0, cmd_a=cmd_b=0, stall_req=0, busy=0, done_cnt=0, gemm_err=0.
REQ-028 Reset mid-operation abandons command; no done_cnt increment; accelerator pulses after reset release while IDLE are ignored.

Configuration
REQ-029 Macro GEMM_TIMEOUT_EN defined: cycle counter runs in WAIT, cleared on entry; reaching TIMEOUT_CYCLES-1 without gemm_done -> DONE with gemm_err=1, no done_cnt increment.
REQ-030 gemm_done coincident with timeout expiry: treated as completion, gemm_err stays 0.
REQ-031 Macro undefined: no counter logic, WAIT unbounded, gemm_err tied 0.

Structure
REQ-032 Package gemm_pkg holds state enum, cmd struct {a,b}, default TIMEOUT_CYCLES constant.
REQ-033 Sub-module gemm_wdt (timeout counter) instantiated only under GEMM_TIMEOUT_EN.

Verification
REQ-034 Single op: is_gemm_ppl=1, op_a=0x1000, op_b=0x2000, cmd_ready=1, gemm_done at cycle 10 -> cmd_a=0x1000/cmd_b=0x2000 at cycle 1, stall_req low at 11, done_cnt=1.
REQ-035 Backpressure: cmd_ready low cycles 1-5 -> cmd_valid held, payload unchanged, WAIT entered cycle 7.
REQ-036 Flush: is_gemm_ppl=1 with flush=1 -> state IDLE, cmd_valid never asserted, stall_req=0.
REQ-037 Reset mid-WAIT: rst low cycle 4 -> all outputs zero immediately; gemm_done at cycle 6 -> done_cnt stays 0.
REQ-038 Timeout (GEMM_TIMEOUT_EN, TIMEOUT_CYCLES=8): no gemm_done -> DONE after 8 WAIT cycles, gemm_err=1; next accepted op clears gemm_err.
REQ-039 Wrap: CNT_W=2, five completed ops -> done_cnt=1.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types for the GEMM issue unit: FSM state encoding, command payload, defaults.
package gemm_pkg;

   localparam int GEMM_DATA_W         = 32;
   localparam int GEMM_TIMEOUT_CYCLES = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } gemm_state_t;

   typedef struct packed {
      logic [GEMM_DATA_W-1:0] a;
      logic [GEMM_DATA_W-1:0] b;
   } gemm_cmd_t;

endpackage

// File: rtl/gemm_issue_unit_if.sv
// Command/completion bus between the issue unit (master) and the GEMM accelerator (slave).
interface gemm_issue_unit_if;
   import gemm_pkg::*;

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [GEMM_DATA_W-1:0] cmd_a;
   logic [GEMM_DATA_W-1:0] cmd_b;
   logic                   gemm_done;

   modport master (
      output cmd_valid,
      output cmd_a,
      output cmd_b,
      input  cmd_ready,
      input  gemm_done
   );

   modport slave (
      input  cmd_valid,
      input  cmd_a,
      input  cmd_b,
      output cmd_ready,
      output gemm_done
   );

endinterface

// File: rtl/gemm_wdt.sv
// WAIT-state watchdog: counts cycles spent in WAIT, flags the last allowed cycle.
module gemm_wdt #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (run && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/gemm_issue_unit.sv
// Issues one GEMM command per decoded instruction and stalls the pipeline until completion.
// Optional WAIT-state timeout enabled by defining GEMM_TIMEOUT_EN.
module gemm_issue_unit
   import gemm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = GEMM_TIMEOUT_CYCLES,
   parameter int CNT_W          = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   is_gemm_ppl,
   input  logic                   flush,
   input  logic [GEMM_DATA_W-1:0] op_a,
   input  logic [GEMM_DATA_W-1:0] op_b,
   gemm_issue_unit_if.master      bus,
   output logic                   stall_req,
   output logic                   busy,
   output logic [CNT_W-1:0]       done_cnt,
   output logic                   gemm_err
);

   gemm_state_t state, state_nxt;
   gemm_cmd_t   cmd_q;
   logic        accept;
   logic        complete;
   logic        wait_entry;
   logic        timeout_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Completion pulses outside WAIT (including stale ones after reset) are ignored.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      complete  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (is_gemm_ppl && !flush) begin
               accept    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.cmd_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            complete = bus.gemm_done;
            if (bus.gemm_done || timeout_hit) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign wait_entry    = (state == ST_ISSUE) && bus.cmd_ready;
   assign stall_req     = accept || (state == ST_ISSUE) || (state == ST_WAIT);
   assign busy          = (state != ST_IDLE);
   assign bus.cmd_valid = (state == ST_ISSUE);
   assign bus.cmd_a     = cmd_q.a;
   assign bus.cmd_b     = cmd_q.b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_q <= '0;
      end else if (accept) begin
         cmd_q <= '{a: op_a, b: op_b};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_cnt <= '0;
      end else if (complete) begin
         done_cnt <= done_cnt + CNT_W'(1);
      end
   end

`ifdef GEMM_TIMEOUT_EN
   gemm_wdt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdt (
      .clk     (clk),
      .rst     (rst),
      .start   (wait_entry),
      .run     (state == ST_WAIT),
      .expired (timeout_hit)
   );

   // A completion coincident with expiry wins, so the error is only raised without gemm_done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gemm_err <= 1'b0;
      end else if (accept) begin
         gemm_err <= 1'b0;
      end else if ((state == ST_WAIT) && timeout_hit && !bus.gemm_done) begin
         gemm_err <= 1'b1;
      end
   end
`else
   logic unused_cfg;

   assign timeout_hit = 1'b0;
   assign gemm_err    = 1'b0;
   assign unused_cfg  = wait_entry ^ (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_gemm_issue_unit.sv
// Directed bench for gemm_issue_unit: vector table for the base flow plus hand-written corner sequences.
module tb_gemm_issue_unit;
   import gemm_pkg::*;

   localparam int CNT_W = 2;
   localparam int TMO   = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              is_gemm_ppl;
   logic              flush;
   logic [31:0]       op_a;
   logic [31:0]       op_b;
   logic              stall_req;
   logic              busy;
   logic [CNT_W-1:0]  done_cnt;
   logic              gemm_err;

   int errors = 0;
   int checks = 0;

   gemm_issue_unit_if bus ();

   gemm_issue_unit #(
      .TIMEOUT_CYCLES(TMO),
      .CNT_W         (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .is_gemm_ppl (is_gemm_ppl),
      .flush       (flush),
      .op_a        (op_a),
      .op_b        (op_b),
      .bus         (bus),
      .stall_req   (stall_req),
      .busy        (busy),
      .done_cnt    (done_cnt),
      .gemm_err    (gemm_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        g;
      logic        f;
      logic [31:0] a;
      logic [31:0] b;
      logic        rdy;
      logic        dn;
      logic        e_valid;
      logic        e_stall;
      logic        e_busy;
      logic [31:0] e_a;
      logic [31:0] e_b;
      logic [1:0]  e_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic g, input logic f, input logic [31:0] a, input logic [31:0] b,
                        input logic rdy, input logic dn);
      is_gemm_ppl   = g;
      flush         = f;
      op_a          = a;
      op_b          = b;
      bus.cmd_ready = rdy;
      bus.gemm_done = dn;
   endtask

   task automatic add(input logic g, input logic f, input logic [31:0] a, input logic [31:0] b,
                      input logic rdy, input logic dn, input logic ev, input logic es,
                      input logic eb, input logic [31:0] ea, input logic [31:0] eb2,
                      input logic [1:0] ec);
      vec_t v;
      v.g = g; v.f = f; v.a = a; v.b = b; v.rdy = rdy; v.dn = dn;
      v.e_valid = ev; v.e_stall = es; v.e_busy = eb;
      v.e_a = ea; v.e_b = eb2; v.e_cnt = ec;
      tbl.push_back(v);
   endtask

   // One full op with cmd_ready at the first ISSUE cycle and gemm_done after wcyc WAIT cycles.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int wcyc);
      drive(1'b1, 1'b0, a, b, 1'b1, 1'b0);
      tick();
      tick();
      for (int w = 0; w < wcyc - 1; w++) tick();
      bus.gemm_done = 1'b1;
      tick();
      drive(1'b1, 1'b0, a, b, 1'b0, 1'b0);
      tick();
      is_gemm_ppl = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Single op, gemm_done at cycle 10
      add(1,0,32'h1000,32'h2000,1,0, 0,1,0, 32'h0,   32'h0,   0);
      add(1,0,32'h1000,32'h2000,1,0, 1,1,1, 32'h1000,32'h2000,0);
      for (int i = 2; i < 10; i++)
         add(1,0,32'h1000,32'h2000,0,0, 0,1,1, 32'h1000,32'h2000,0);
      add(1,0,32'h1000,32'h2000,0,1, 0,1,1, 32'h1000,32'h2000,0);
      add(1,0,32'h1000,32'h2000,0,0, 0,0,1, 32'h1000,32'h2000,1);
      add(0,0,32'h0,   32'h0,   0,0, 0,0,0, 32'h1000,32'h2000,1);
      // Flush while a GEMM is presented: no capture, no stall
      add(1,1,32'h3333,32'h4444,1,0, 0,0,0, 32'h1000,32'h2000,1);
      add(1,1,32'h3333,32'h4444,1,0, 0,0,0, 32'h1000,32'h2000,1);
      add(0,0,32'h0,   32'h0,   1,0, 0,0,0, 32'h1000,32'h2000,1);
      // gemm_done during ISSUE is ignored
      add(1,0,32'h5,   32'h6,   0,0, 0,1,0, 32'h1000,32'h2000,1);
      add(1,0,32'h5,   32'h6,   0,1, 1,1,1, 32'h5,   32'h6,   1);
      add(1,0,32'h5,   32'h6,   1,0, 1,1,1, 32'h5,   32'h6,   1);
      add(1,0,32'h5,   32'h6,   0,1, 0,1,1, 32'h5,   32'h6,   1);
      add(1,0,32'h5,   32'h6,   0,0, 0,0,1, 32'h5,   32'h6,   2);
      add(0,0,32'h0,   32'h0,   0,0, 0,0,0, 32'h5,   32'h6,   2);

      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2;
      chk("rst_valid", bus.cmd_valid, 0);
      chk("rst_cmd_a", bus.cmd_a, 0);
      chk("rst_cmd_b", bus.cmd_b, 0);
      chk("rst_stall", stall_req, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_cnt",   done_cnt, 0);
      chk("rst_err",   gemm_err, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].g, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rdy, tbl[i].dn);
         #2;
         chk($sformatf("v%0d_valid", i), bus.cmd_valid, tbl[i].e_valid);
         chk($sformatf("v%0d_stall", i), stall_req,     tbl[i].e_stall);
         chk($sformatf("v%0d_busy",  i), busy,          tbl[i].e_busy);
         chk($sformatf("v%0d_cmd_a", i), bus.cmd_a,     tbl[i].e_a);
         chk($sformatf("v%0d_cmd_b", i), bus.cmd_b,     tbl[i].e_b);
         chk($sformatf("v%0d_cnt",   i), done_cnt,      tbl[i].e_cnt);
         chk($sformatf("v%0d_err",   i), gemm_err,      1'b0);
         tick();
      end

      // Backpressure: cmd_ready low cycles 1-5, operands/flush wiggled, WAIT at cycle 7
      drive(1'b1, 1'b0, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0);
      tick();
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, (k == 3), 32'h100 + k, 32'h200 + k, 1'b0, 1'b0);
         #2;
         chk($sformatf("bp%0d_valid", k), bus.cmd_valid, 1);
         chk($sformatf("bp%0d_cmd_a", k), bus.cmd_a, 32'hAAAA);
         chk($sformatf("bp%0d_cmd_b", k), bus.cmd_b, 32'hBBBB);
         chk($sformatf("bp%0d_stall", k), stall_req, 1);
         tick();
      end
      drive(1'b1, 1'b0, 32'hAAAA, 32'hBBBB, 1'b1, 1'b0);
      #2;
      chk("bp6_valid", bus.cmd_valid, 1);
      tick();
      bus.cmd_ready = 1'b0;
      #2;
      chk("bp7_valid", bus.cmd_valid, 0);
      chk("bp7_busy",  busy, 1);
      chk("bp7_stall", stall_req, 1);
      bus.gemm_done = 1'b1;
      tick();
      bus.gemm_done = 1'b0;
      #2;
      chk("bp8_stall", stall_req, 0);
      chk("bp8_cnt",   done_cnt, 3);
      tick();
      is_gemm_ppl = 1'b0;
      #2;
      chk("bp9_busy", busy, 0);
      tick();

      // Reset in the middle of WAIT, stale completion afterwards
      drive(1'b1, 1'b0, 32'h11, 32'h22, 1'b1, 1'b0);
      tick();
      tick();
      bus.cmd_ready = 1'b0;
      tick();
      tick();
      is_gemm_ppl = 1'b0;
      rst = 1'b0;
      #1;
      chk("mr_valid", bus.cmd_valid, 0);
      chk("mr_cmd_a", bus.cmd_a, 0);
      chk("mr_cmd_b", bus.cmd_b, 0);
      chk("mr_stall", stall_req, 0);
      chk("mr_busy",  busy, 0);
      chk("mr_cnt",   done_cnt, 0);
      tick();
      rst = 1'b1;
      tick();
      bus.gemm_done = 1'b1;
      #2;
      chk("mr6_busy",  busy, 0);
      chk("mr6_stall", stall_req, 0);
      tick();
      bus.gemm_done = 1'b0;
      #2;
      chk("mr7_cnt",  done_cnt, 0);
      chk("mr7_busy", busy, 0);
      tick();

      // Counter wrap with CNT_W=2
      for (int n = 0; n < 5; n++) begin
         run_op(32'h40 + n, 32'h80 + n, 2 + n);
         #2;
         chk($sformatf("wrap%0d_cnt", n), done_cnt, (n + 1) % 4);
         chk($sformatf("wrap%0d_busy", n), busy, 0);
         tick();
      end

`ifdef GEMM_TIMEOUT_EN
      // No completion: 8 WAIT cycles, then DONE with the error flag
      drive(1'b1, 1'b0, 32'h77, 32'h88, 1'b1, 1'b0);
      tick();
      tick();
      bus.cmd_ready = 1'b0;
      for (int w = 0; w < TMO; w++) begin
         #2;
         chk($sformatf("to_w%0d_stall", w), stall_req, 1);
         tick();
      end
      #2;
      chk("to_done_stall", stall_req, 0);
      chk("to_done_busy",  busy, 1);
      chk("to_done_err",   gemm_err, 1);
      chk("to_done_cnt",   done_cnt, 1);
      tick();
      is_gemm_ppl = 1'b0;
      #2;
      chk("to_idle_busy", busy, 0);
      chk("to_idle_err",  gemm_err, 1);
      tick();
      // Next op clears the flag; completion coincident with expiry counts as success
      drive(1'b1, 1'b0, 32'h99, 32'hAA, 1'b1, 1'b0);
      tick();
      #2;
      chk("to_clr_err", gemm_err, 0);
      tick();
      bus.cmd_ready = 1'b0;
      for (int w = 0; w < TMO - 1; w++) tick();
      bus.gemm_done = 1'b1;
      tick();
      bus.gemm_done = 1'b0;
      #2;
      chk("to_coin_stall", stall_req, 0);
      chk("to_coin_err",   gemm_err, 0);
      chk("to_coin_cnt",   done_cnt, 2);
      tick();
      is_gemm_ppl = 1'b0;
      tick();
`else
      // WAIT is unbounded without the timeout feature
      drive(1'b1, 1'b0, 32'h77, 32'h88, 1'b1, 1'b0);
      tick();
      tick();
      bus.cmd_ready = 1'b0;
      repeat (40) tick();
      #2;
      chk("nt_busy",  busy, 1);
      chk("nt_stall", stall_req, 1);
      chk("nt_err",   gemm_err, 0);
      bus.gemm_done = 1'b1;
      tick();
      bus.gemm_done = 1'b0;
      #2;
      chk("nt_done_stall", stall_req, 0);
      chk("nt_done_cnt",   done_cnt, 2);
      chk("nt_done_err",   gemm_err, 0);
      tick();
      is_gemm_ppl = 1'b0;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
